// File: rtl/arb_req_gen.sv
// arb_req_gen: two independent clients, each with a 2-deep burst-length FIFO feeding a
// request/transfer FSM that drives a shared downstream arbiter and counts out burst beats.
module arb_req_gen #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cmd_valid,
    input  logic [LEN_W-1:0] cmd_len0,
    input  logic [LEN_W-1:0] cmd_len1,
    output logic [1:0]       cmd_ready,
    output logic [1:0]       request,
    input  logic [1:0]       grant,
    output logic [1:0]       beat,
    output logic [1:0]       done,
    output logic             err
);

    // cmd_valid/cmd_ready: a command transfers on a posedge where both bits are 1; valid
    // may rise independently of ready, and ready depends only on registered FIFO occupancy.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    state_e           state_q    [2];
    state_e           state_d    [2];
    logic [LEN_W-1:0] cnt_q      [2];
    logic [LEN_W-1:0] cnt_d      [2];
    logic [LEN_W-1:0] fifo_mem_q [2][2];
    logic [LEN_W-1:0] fifo_mem_d [2][2];
    logic [1:0]       fifo_cnt_q [2];
    logic [1:0]       fifo_cnt_d [2];
    logic             fifo_rd_q  [2];
    logic             fifo_rd_d  [2];
    logic             fifo_wr_q  [2];
    logic             fifo_wr_d  [2];
    logic             err_q;
    logic             err_d;

    logic [LEN_W-1:0] cmd_len    [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             grant_ok;

    assign cmd_len[0] = cmd_len0;
    assign cmd_len[1] = cmd_len1;

    // A 2'b11 grant is a protocol violation: it freezes both clients for that cycle.
    assign grant_ok = (grant != 2'b11);
    assign err      = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fifo_mem_d = fifo_mem_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        err_d      = err_q | ~grant_ok;
        push       = 2'b00;
        pop        = 2'b00;
        cmd_ready  = 2'b00;
        request    = 2'b00;
        beat       = 2'b00;
        done       = 2'b00;

        for (int i = 0; i < 2; i++) begin
            cmd_ready[i] = (fifo_cnt_q[i] != 2'd2);
            push[i]      = cmd_valid[i] && cmd_ready[i];
            request[i]   = (state_q[i] != ST_IDLE);
            beat[i]      = (state_q[i] == ST_XFER) && grant[i] && grant_ok;
            done[i]      = beat[i] && (cnt_q[i] == '0);

            case (state_q[i])
                ST_IDLE: begin
                    if (fifo_cnt_q[i] != 2'd0) begin
                        pop[i]     = 1'b1;
                        cnt_d[i]   = fifo_mem_q[i][fifo_rd_q[i]];
                        state_d[i] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (grant[i] && grant_ok) begin
                        state_d[i] = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!grant_ok) begin
                        state_d[i] = ST_XFER;
                    end else if (!grant[i]) begin
                        // Preempted: wait for re-grant with the remaining count intact.
                        state_d[i] = ST_REQ;
                    end else if (cnt_q[i] == '0) begin
                        if (fifo_cnt_q[i] != 2'd0) begin
                            pop[i]     = 1'b1;
                            cnt_d[i]   = fifo_mem_q[i][fifo_rd_q[i]];
                            state_d[i] = ST_REQ;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - LEN_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            if (push[i]) begin
                fifo_mem_d[i][fifo_wr_q[i]] = cmd_len[i];
                fifo_wr_d[i]                = ~fifo_wr_q[i];
            end
            if (pop[i]) begin
                fifo_rd_d[i] = ~fifo_rd_q[i];
            end
            fifo_cnt_d[i] = fifo_cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]       <= ST_IDLE;
                cnt_q[i]         <= '0;
                fifo_cnt_q[i]    <= 2'd0;
                fifo_rd_q[i]     <= 1'b0;
                fifo_wr_q[i]     <= 1'b0;
                fifo_mem_q[i][0] <= '0;
                fifo_mem_q[i][1] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fifo_mem_q <= fifo_mem_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_arb_req_gen.sv
// Testbench for arb_req_gen: directed scenarios plus a randomized round-robin run, with a
// scoreboard of expected burst lengths popped by a negedge monitor on every done pulse.
module tb_arb_req_gen;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       cmd_valid;
    logic [LEN_W-1:0] cmd_len0;
    logic [LEN_W-1:0] cmd_len1;
    logic [1:0]       cmd_ready;
    logic [1:0]       request;
    logic [1:0]       grant;
    logic [1:0]       beat;
    logic [1:0]       done;
    logic             err;

    arb_req_gen #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_len0  (cmd_len0),
        .cmd_len1  (cmd_len1),
        .cmd_ready (cmd_ready),
        .request   (request),
        .grant     (grant),
        .beat      (beat),
        .done      (done),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [LEN_W:0] exp_q0[$];
    logic [LEN_W:0] exp_q1[$];
    int run_beats[2];
    int beat_tot[2];
    int done_tot[2];
    int acc_tot[2];
    int len_sum[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: at each negedge, close out bursts on done, and record commands that the
    // upcoming posedge will accept as expected beat counts (len + 1).
    task automatic monitor();
        logic [LEN_W:0] exp_len;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q0.delete();
                exp_q1.delete();
                run_beats[0] = 0;
                run_beats[1] = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (beat[i]) begin
                        run_beats[i]++;
                        beat_tot[i]++;
                    end
                    if (done[i]) begin
                        done_tot[i]++;
                        check($sformatf("done_has_beat_c%0d", i), 32'(beat[i]), 32'd1);
                        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL sb_underflow_c%0d: got done with %0d beats expected no done", i, run_beats[i]);
                        end else begin
                            if (i == 0) exp_len = exp_q0.pop_front();
                            else        exp_len = exp_q1.pop_front();
                            check($sformatf("burst_beats_c%0d", i), 32'(run_beats[i]), 32'(exp_len));
                        end
                        run_beats[i] = 0;
                    end
                end
                if (cmd_valid[0] && cmd_ready[0]) begin
                    exp_q0.push_back((LEN_W+1)'(cmd_len0) + (LEN_W+1)'(1));
                    acc_tot[0]++;
                    len_sum[0] += int'(cmd_len0) + 1;
                end
                if (cmd_valid[1] && cmd_ready[1]) begin
                    exp_q1.push_back((LEN_W+1)'(cmd_len1) + (LEN_W+1)'(1));
                    acc_tot[1]++;
                    len_sum[1] += int'(cmd_len1) + 1;
                end
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic run_until_done(input int c, input logic [1:0] g, input string name);
        int cyc;
        bit seen;
        grant = g;
        cyc   = 0;
        seen  = 0;
        while (!seen && cyc < 60) begin
            #1;
            if (done[c]) seen = 1;
            tick();
            cyc++;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    function automatic logic [1:0] rr_grant(input int pref);
        logic [1:0] g;
        g = 2'b00;
        if ($urandom_range(0, 4) != 0) begin
            if (request[pref])          g = 2'(1 << pref);
            else if (request[1 - pref]) g = 2'(1 << (1 - pref));
        end
        return g;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int nb, nd, gap, cyc, pref, beat5;
        int bb[2], db[2], ab[2], lb[2];
        bit saw_done, saw_req;

        for (int i = 0; i < 2; i++) begin
            run_beats[i] = 0; beat_tot[i] = 0; done_tot[i] = 0; acc_tot[i] = 0; len_sum[i] = 0;
        end
        rst_n     = 1'b0;
        cmd_valid = 2'b00;
        cmd_len0  = '0;
        cmd_len1  = '0;
        grant     = 2'b00;
        fork
            monitor();
        join_none

        tick();
        tick();
        check("rst_request", 32'(request), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd3);
        check("rst_beat", 32'(beat), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single len=2 burst on client 0, grant held; command offered right after reset.
        rst_n     = 1'b1;
        grant     = 2'b01;
        cmd_valid = 2'b01;
        cmd_len0  = 4'd2;
        #1;
        check("a_idle_grant_no_beat", 32'(beat), 32'd0);
        tick();
        cmd_valid = 2'b00;
        #1;
        check("a_no_req_at_push", 32'(request), 32'd0);
        tick();
        check("a_req_rise", 32'(request), 32'd1);
        check("a_req_no_beat", 32'(beat), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("a_beat%0d", k), 32'(beat), 32'd1);
            check($sformatf("a_done%0d", k), 32'(done), (k == 2) ? 32'd1 : 32'd0);
        end
        tick();
        check("a_req_fall", 32'(request), 32'd0);
        check("a_beat_end", 32'(beat), 32'd0);

        // Client 1: three pushes, FIFO fills, then back-to-back bursts.
        grant     = 2'b00;
        cmd_valid = 2'b10;
        cmd_len1  = 4'd1;
        tick();
        cmd_len1  = 4'd0;
        tick();
        cmd_len1  = 4'd2;
        tick();
        cmd_valid = 2'b00;
        #1;
        check("b_full_ready", 32'(cmd_ready), 32'd1);
        check("b_req_held", 32'(request), 32'd2);
        tick();
        check("b_still_full", 32'(cmd_ready), 32'd1);
        grant = 2'b10;
        nb = 0; nd = 0; gap = 0; cyc = 0;
        while (nd < 3 && cyc < 40) begin
            #1;
            if (!request[1]) gap++;
            if (beat[1]) nb++;
            if (done[1]) nd++;
            tick();
            cyc++;
        end
        check("b_dones", 32'(nd), 32'd3);
        check("b_beats", 32'(nb), 32'd6);
        check("b_req_gaps", 32'(gap), 32'd0);
        check("b_req_fall", 32'(request), 32'd0);
        check("b_ready_back", 32'(cmd_ready), 32'd3);

        // Client 0 len=3 with a 3-cycle grant gap.
        grant     = 2'b00;
        cmd_valid = 2'b01;
        cmd_len0  = 4'd3;
        tick();
        cmd_valid = 2'b00;
        tick();
        nb = 0; nd = 0; gap = 0; beat5 = 1;
        for (int k = 0; k < 20; k++) begin
            grant = (k < 2 || k >= 5) ? 2'b01 : 2'b00;
            #1;
            if (beat[0]) nb++;
            if (done[0]) nd++;
            if (k >= 2 && k <= 4 && !request[0]) gap++;
            if (k == 5) beat5 = int'(beat[0]);
            tick();
        end
        check("c_beats", 32'(nb), 32'd4);
        check("c_dones", 32'(nd), 32'd1);
        check("c_req_in_gap", 32'(gap), 32'd0);
        check("c_regrant_from_req", 32'(beat5), 32'd0);

        // Illegal 2'b11 grant with both clients in REQ.
        grant     = 2'b00;
        cmd_valid = 2'b11;
        cmd_len0  = 4'd1;
        cmd_len1  = 4'd0;
        tick();
        cmd_valid = 2'b00;
        tick();
        check("d_both_req", 32'(request), 32'd3);
        grant = 2'b11;
        #1;
        check("d_no_beat_on_11", 32'(beat), 32'd0);
        tick();
        check("d_err_set", 32'(err), 32'd1);
        grant = 2'b01;
        #1;
        check("d_no_advance", 32'(beat), 32'd0);
        check("d_req_kept", 32'(request), 32'd3);
        tick();
        run_until_done(0, 2'b01, "d_done_c0");
        run_until_done(1, 2'b10, "d_done_c1");
        grant = 2'b00;
        #1;
        check("d_err_sticky", 32'(err), 32'd1);

        // Reset clears err; then a len=15 burst aborted by reset at its 5th beat.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("e_err_cleared", 32'(err), 32'd0);
        cmd_valid = 2'b01;
        cmd_len0  = 4'd15;
        tick();
        cmd_len0  = 4'd5;
        tick();
        cmd_len0  = 4'd7;
        tick();
        cmd_valid = 2'b00;
        grant     = 2'b01;
        nb = 0; cyc = 0; saw_done = 0;
        while (nb < 5 && cyc < 40) begin
            #1;
            if (beat[0]) nb++;
            if (done[0]) saw_done = 1;
            if (nb < 5) tick();
            cyc++;
        end
        check("e_reach_beat5", 32'(nb), 32'd5);
        rst_n = 1'b0;
        tick();
        check("e_rst_request", 32'(request), 32'd0);
        check("e_rst_beat", 32'(beat), 32'd0);
        check("e_rst_done", 32'(done), 32'd0);
        check("e_rst_ready", 32'(cmd_ready), 32'd3);
        check("e_rst_err", 32'(err), 32'd0);
        rst_n   = 1'b1;
        saw_req = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (done[0]) saw_done = 1;
            if (request != 2'b00) saw_req = 1;
            tick();
        end
        check("e_no_done", 32'(saw_done), 32'd0);
        check("e_queue_lost", 32'(saw_req), 32'd0);

        // Randomized run against a round-robin arbiter with random idle cycles.
        for (int i = 0; i < 2; i++) begin
            bb[i] = beat_tot[i]; db[i] = done_tot[i]; ab[i] = acc_tot[i]; lb[i] = len_sum[i];
        end
        pref = 0;
        cyc  = 0;
        while ((acc_tot[0] + acc_tot[1] - ab[0] - ab[1]) < 1000 && cyc < 40000) begin
            cmd_valid[0] = ($urandom_range(0, 2) != 0);
            cmd_valid[1] = ($urandom_range(0, 2) != 0);
            cmd_len0     = LEN_W'($urandom_range(0, 15));
            cmd_len1     = LEN_W'($urandom_range(0, 15));
            grant        = rr_grant(pref);
            #1;
            if (done[pref]) pref = 1 - pref;
            tick();
            cyc++;
        end
        check("f_accepted_1000", 32'((acc_tot[0] + acc_tot[1] - ab[0] - ab[1]) >= 1000), 32'd1);
        cmd_valid = 2'b00;
        cyc = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && cyc < 5000) begin
            grant = rr_grant(pref);
            #1;
            if (done[pref]) pref = 1 - pref;
            tick();
            cyc++;
        end
        grant = 2'b00;
        check("f_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("f_total_beats_c%0d", i), 32'(beat_tot[i] - bb[i]), 32'(len_sum[i] - lb[i]));
            check($sformatf("f_done_count_c%0d", i), 32'(done_tot[i] - db[i]), 32'(acc_tot[i] - ab[i]));
        end
        check("f_err_clear", 32'(err), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
